// File: rtl/iso16_delivery_sequencer_if.sv
// Plugin-fabric and seal-core handshake bundle for iso16_delivery_sequencer.
// master = sequencer side, slave = plugin fabric / SHA3 core side.
interface iso16_delivery_sequencer_if #(
  parameter int unsigned NUM_PLUGINS = 4,
  parameter int unsigned WARP_WIDTH  = 16,
  parameter int unsigned ERROR_WIDTH = 32
);
  localparam int unsigned MsgWidth = 16 + 3 * WARP_WIDTH + ERROR_WIDTH + NUM_PLUGINS + 3;

  logic [NUM_PLUGINS-1:0]             plugin_valid;
  logic [NUM_PLUGINS-1:0]             plugin_ready;
  logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_x;
  logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_y;
  logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_z;
  logic [NUM_PLUGINS*ERROR_WIDTH-1:0] plugin_error;
  logic                               seal_req;
  logic                               seal_ack;
  logic                               seal_done;
  logic [255:0]                       seal_digest;
  logic [MsgWidth-1:0]                seal_msg;

  modport master (
    output plugin_ready, seal_req, seal_msg,
    input  plugin_valid, plugin_warp_x, plugin_warp_y, plugin_warp_z, plugin_error,
    input  seal_ack, seal_done, seal_digest
  );

  modport slave (
    input  plugin_ready, seal_req, seal_msg,
    output plugin_valid, plugin_warp_x, plugin_warp_y, plugin_warp_z, plugin_error,
    output seal_ack, seal_done, seal_digest
  );
endinterface

// File: rtl/iso16_delivery_sequencer.sv
// ISO-16 true delivery loop: collect plugin warps/errors, warp lattice, check, seal.
// Define ISO16_SAT_ACCUM_EN to make error accumulation saturate instead of wrap.
module iso16_delivery_sequencer #(
  parameter int unsigned NUM_PLUGINS    = 4,
  parameter int unsigned WARP_WIDTH     = 16,
  parameter int unsigned ERROR_WIDTH    = 32,
  parameter int unsigned LATTICE_SIZE   = 16,
  parameter int unsigned PLUGIN_TIMEOUT = 64,
  parameter int unsigned SEAL_TIMEOUT   = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic [15:0]                     vector_id,
  input  logic [ERROR_WIDTH-1:0]          epsilon,
  input  logic                            lat_we,
  input  logic [$clog2(LATTICE_SIZE)-1:0] lat_addr,
  input  logic [WARP_WIDTH-1:0]           lat_x,
  input  logic [WARP_WIDTH-1:0]           lat_y,
  input  logic [WARP_WIDTH-1:0]           lat_z,
  iso16_delivery_sequencer_if.master      bus,
  output logic [2:0]                      state,
  output logic [WARP_WIDTH-1:0]           warp_sum_x,
  output logic [WARP_WIDTH-1:0]           warp_sum_y,
  output logic [WARP_WIDTH-1:0]           warp_sum_z,
  output logic [ERROR_WIDTH-1:0]          error_sum,
  output logic [NUM_PLUGINS-1:0]          plugin_missing,
  output logic                            symmetry_ok,
  output logic                            error_ok,
  output logic                            true_delivery,
  output logic [255:0]                    seal,
  output logic [1:0]                      status,
  output logic                            done
);
  localparam int unsigned PW   = (NUM_PLUGINS > 1) ? $clog2(NUM_PLUGINS) : 1;
  localparam int unsigned TW   = $clog2(PLUGIN_TIMEOUT + 1);
  localparam int unsigned KW   = $clog2(LATTICE_SIZE);
  localparam int unsigned SW   = $clog2(SEAL_TIMEOUT + 1);
  localparam int unsigned Half = LATTICE_SIZE / 2;

  typedef enum logic [2:0] {
    StIdle = 3'd0, StCollect = 3'd1, StApply = 3'd2, StCheck = 3'd3,
    StSeal = 3'd4, StWait = 3'd5, StDone = 3'd6
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           p_q, p_d;
  logic [TW-1:0]           wait_q, wait_d;
  logic [KW-1:0]           k_q, k_d;
  logic [SW-1:0]           scnt_q, scnt_d;
  logic [15:0]             vid_q, vid_d;
  logic [ERROR_WIDTH-1:0]  eps_q, eps_d, err_q, err_d, err_p, err_acc;
  logic [WARP_WIDTH-1:0]   wx_q, wx_d, wy_q, wy_d, wz_q, wz_d, wx_p, wy_p, wz_p;
  logic [NUM_PLUGINS-1:0]  miss_q, miss_d;
  logic                    sym_q, sym_d, eok_q, eok_d, td_q, td_d, done_d, valid_p, mismatch;
  logic [255:0]            seal_q, seal_d;
  logic [1:0]              status_q, status_d;
  logic [ERROR_WIDTH:0]    err_wide;
  logic [KW-1:0]           mir;

  logic [WARP_WIDTH-1:0] can_x [LATTICE_SIZE];
  logic [WARP_WIDTH-1:0] can_y [LATTICE_SIZE];
  logic [WARP_WIDTH-1:0] can_z [LATTICE_SIZE];
  logic [WARP_WIDTH-1:0] wrp_x [LATTICE_SIZE];
  logic [WARP_WIDTH-1:0] wrp_y [LATTICE_SIZE];
  logic [WARP_WIDTH-1:0] wrp_z [LATTICE_SIZE];

  // Lattice storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (lat_we && state_q == StIdle) begin
      can_x[lat_addr] <= lat_x;
      can_y[lat_addr] <= lat_y;
      can_z[lat_addr] <= lat_z;
    end
    if (state_q == StApply) begin
      for (int i = 0; i < LATTICE_SIZE; i++) begin
        wrp_x[i] <= can_x[i] + wx_q;
        wrp_y[i] <= can_y[i] + wy_q;
        wrp_z[i] <= can_z[i] + wz_q;
      end
    end
  end

  always_comb begin
    valid_p = bus.plugin_valid[p_q];
    wx_p    = bus.plugin_warp_x[32'(p_q) * WARP_WIDTH +: WARP_WIDTH];
    wy_p    = bus.plugin_warp_y[32'(p_q) * WARP_WIDTH +: WARP_WIDTH];
    wz_p    = bus.plugin_warp_z[32'(p_q) * WARP_WIDTH +: WARP_WIDTH];
    err_p   = bus.plugin_error[32'(p_q) * ERROR_WIDTH +: ERROR_WIDTH];
    err_wide = {1'b0, err_q} + {1'b0, err_p};
`ifdef ISO16_SAT_ACCUM_EN
    err_acc = err_wide[ERROR_WIDTH] ? '1 : err_wide[ERROR_WIDTH-1:0];
`else
    err_acc = err_wide[ERROR_WIDTH-1:0];
`endif
    mir      = KW'(LATTICE_SIZE - 1) - k_q;
    mismatch = (wrp_x[k_q] != wrp_x[mir]) || (wrp_y[k_q] != wrp_y[mir]) ||
               (wrp_z[k_q] != wrp_z[mir]);
  end

  always_comb begin
    state_d = state_q;  p_d = p_q;     wait_d = wait_q;  k_d = k_q;    scnt_d = scnt_q;
    vid_d = vid_q;      eps_d = eps_q; err_d = err_q;    wx_d = wx_q;  wy_d = wy_q;
    wz_d = wz_q;        miss_d = miss_q; sym_d = sym_q;  eok_d = eok_q; td_d = td_q;
    seal_d = seal_q;    status_d = status_q;
    if (abort && state_q inside {StCollect, StApply, StCheck, StSeal, StWait}) begin
      state_d  = StDone;
      status_d = 2'd3;
    end else begin
      unique case (state_q)
        StIdle: if (start) begin
          state_d = StCollect; p_d = '0; wait_d = '0; vid_d = vector_id; eps_d = epsilon;
          err_d = '0; wx_d = '0; wy_d = '0; wz_d = '0; miss_d = '0;
          sym_d = 1'b0; eok_d = 1'b0; td_d = 1'b0; seal_d = '0; status_d = 2'd0;
        end
        StCollect: begin
          wait_d = wait_q + TW'(1);
          if (valid_p) begin
            err_d = err_acc; wx_d = wx_q + wx_p; wy_d = wy_q + wy_p; wz_d = wz_q + wz_p;
          end else if (wait_q == TW'(PLUGIN_TIMEOUT - 1)) begin
            miss_d[p_q] = 1'b1;
          end
          if (valid_p || wait_q == TW'(PLUGIN_TIMEOUT - 1)) begin
            p_d    = p_q + PW'(1);
            wait_d = '0;
            if (p_q == PW'(NUM_PLUGINS - 1)) state_d = StApply;
          end
        end
        StApply: begin
          state_d = StCheck; k_d = '0; sym_d = 1'b1; eok_d = (err_q <= eps_q);
        end
        StCheck: begin
          k_d = k_q + KW'(1);
          if (mismatch) sym_d = 1'b0;
          if (k_q == KW'(Half - 1)) begin
            state_d = StSeal;
            scnt_d  = '0;
            td_d    = sym_q && !mismatch && eok_q && (miss_q == '0);
          end
        end
        StSeal, StWait: begin
          scnt_d = scnt_q + SW'(1);
          // seal_done beats timeout; timeout beats a late seal_ack.
          if (state_q == StWait && bus.seal_done) begin
            state_d = StDone; seal_d = bus.seal_digest; status_d = td_q ? 2'd0 : 2'd1;
          end else if (scnt_q == SW'(SEAL_TIMEOUT - 1)) begin
            state_d = StDone; seal_d = '0; status_d = 2'd2;
          end else if (state_q == StSeal && bus.seal_ack) begin
            state_d = StWait;
          end
        end
        StDone: if (!start) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle; p_q <= '0; wait_q <= '0; k_q <= '0; scnt_q <= '0;
      vid_q <= '0; eps_q <= '0; err_q <= '0; wx_q <= '0; wy_q <= '0; wz_q <= '0;
      miss_q <= '0; sym_q <= 1'b0; eok_q <= 1'b0; td_q <= 1'b0; seal_q <= '0;
      status_q <= 2'd0; done <= 1'b0;
    end else begin
      state_q <= state_d; p_q <= p_d; wait_q <= wait_d; k_q <= k_d; scnt_q <= scnt_d;
      vid_q <= vid_d; eps_q <= eps_d; err_q <= err_d; wx_q <= wx_d; wy_q <= wy_d; wz_q <= wz_d;
      miss_q <= miss_d; sym_q <= sym_d; eok_q <= eok_d; td_q <= td_d; seal_q <= seal_d;
      status_q <= status_d; done <= done_d;
    end
  end

  always_comb begin
    bus.plugin_ready = '0;
    if (state_q == StCollect && !abort) bus.plugin_ready[p_q] = 1'b1;
  end

  assign bus.seal_req = (state_q == StSeal) && !abort;
  assign bus.seal_msg = {vid_q, wx_q, wy_q, wz_q, err_q, miss_q, sym_q, eok_q, td_q};

  assign state          = state_q;
  assign warp_sum_x     = wx_q;
  assign warp_sum_y     = wy_q;
  assign warp_sum_z     = wz_q;
  assign error_sum      = err_q;
  assign plugin_missing = miss_q;
  assign symmetry_ok    = sym_q;
  assign error_ok       = eok_q;
  assign true_delivery  = td_q;
  assign seal           = seal_q;
  assign status         = status_q;
endmodule

// File: tb/tb_iso16_delivery_sequencer.sv
// Scoreboard bench for iso16_delivery_sequencer: driver pushes expected run results,
// a monitor pops and compares on every rising done.
module tb_iso16_delivery_sequencer;
  localparam int MW = 16 + 3 * 16 + 32 + 4 + 3;

  logic         clk = 1'b0;
  logic         rst_n, start, abort, lat_we;
  logic [15:0]  vector_id;
  logic [31:0]  epsilon;
  logic [3:0]   lat_addr;
  logic [15:0]  lat_x, lat_y, lat_z;
  logic [2:0]   state;
  logic [15:0]  warp_sum_x, warp_sum_y, warp_sum_z;
  logic [31:0]  error_sum;
  logic [3:0]   plugin_missing;
  logic         symmetry_ok, error_ok, true_delivery, done;
  logic [255:0] seal;
  logic [1:0]   status;

  iso16_delivery_sequencer_if #(.NUM_PLUGINS(4), .WARP_WIDTH(16), .ERROR_WIDTH(32)) bus_if ();

  iso16_delivery_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vector_id(vector_id),
    .epsilon(epsilon), .lat_we(lat_we), .lat_addr(lat_addr), .lat_x(lat_x), .lat_y(lat_y),
    .lat_z(lat_z), .bus(bus_if), .state(state), .warp_sum_x(warp_sum_x),
    .warp_sum_y(warp_sum_y), .warp_sum_z(warp_sum_z), .error_sum(error_sum),
    .plugin_missing(plugin_missing), .symmetry_ok(symmetry_ok), .error_ok(error_ok),
    .true_delivery(true_delivery), .seal(seal), .status(status), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  vid;
    logic [1:0]   status;
    logic [31:0]  err;
    logic [15:0]  wx, wy, wz;
    logic [3:0]   miss;
    logic         sym, eok, td;
    logic [255:0] seal;
    int           lat;
    int           start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic ack_en = 1'b1;
  logic done_prev = 1'b0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Zero-wait SHA3 core model: ack while seal_req, done pulse the following cycle.
  initial begin
    bus_if.seal_ack  = 1'b0;
    bus_if.seal_done = 1'b0;
    forever begin
      @(negedge clk);
      bus_if.seal_done = bus_if.seal_ack;
      bus_if.seal_ack  = ack_en && bus_if.seal_req;
    end
  end

  // Monitor: compare a full result record on every rising done.
  initial forever begin
    @(negedge clk);
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected done: got status %0d want no run pending", status);
      end else begin
        exp_t e;
        logic [MW-1:0] msg;
        e   = exp_q.pop_front();
        msg = {e.vid, e.wx, e.wy, e.wz, e.err, e.miss, e.sym, e.eok, e.td};
        chk($sformatf("v%0h status", e.vid), 256'(status), 256'(e.status));
        chk($sformatf("v%0h error_sum", e.vid), 256'(error_sum), 256'(e.err));
        chk($sformatf("v%0h warp_x", e.vid), 256'(warp_sum_x), 256'(e.wx));
        chk($sformatf("v%0h warp_y", e.vid), 256'(warp_sum_y), 256'(e.wy));
        chk($sformatf("v%0h warp_z", e.vid), 256'(warp_sum_z), 256'(e.wz));
        chk($sformatf("v%0h missing", e.vid), 256'(plugin_missing), 256'(e.miss));
        chk($sformatf("v%0h symmetry_ok", e.vid), 256'(symmetry_ok), 256'(e.sym));
        chk($sformatf("v%0h error_ok", e.vid), 256'(error_ok), 256'(e.eok));
        chk($sformatf("v%0h true_delivery", e.vid), 256'(true_delivery), 256'(e.td));
        chk($sformatf("v%0h seal", e.vid), seal, e.seal);
        chk($sformatf("v%0h seal_msg", e.vid), 256'(bus_if.seal_msg), 256'(msg));
        chk($sformatf("v%0h done latency", e.vid), 256'(cyc - e.start_cyc), 256'(e.lat));
        chk($sformatf("v%0h state DONE", e.vid), 256'(state), 256'(6));
      end
    end
    done_prev = done;
  end

  task automatic load_lattice();
    for (int i = 0; i < 16; i++) begin
      int m;
      m = (i < 8) ? i : 15 - i;
      @(negedge clk);
      lat_we = 1'b1; lat_addr = 4'(i);
      lat_x = 16'(m * 3); lat_y = 16'(100 + m); lat_z = -16'(m);
    end
    @(negedge clk);
    lat_we = 1'b0;
  endtask

  task automatic run(input exp_t e, input logic [31:0] eps, input logic [3:0] valid,
                     input logic ack, input int abort_at);
    exp_t  ex;
    @(negedge clk);
    ex = e;
    ex.start_cyc = cyc;
    exp_q.push_back(ex);
    vector_id = e.vid; epsilon = eps; bus_if.plugin_valid = valid; ack_en = ack;
    bus_if.seal_digest = {8{32'hD16E_0000 | 32'(e.vid)}};
    start = 1'b1;
    if (abort_at > 0) begin
      while (cyc < ex.start_cyc + abort_at) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL v%0h done timeout: got done 0 want 1", e.vid);
    end
    start = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0h back to IDLE", e.vid), 256'(state), 256'(0));
  endtask

  function automatic exp_t mk(input logic [15:0] vid, input logic [1:0] st,
                              input logic [31:0] err, input logic [15:0] wx, wy, wz,
                              input logic [3:0] miss, input logic sym, eok, td,
                              input logic seal_on, input int lat);
    exp_t e;
    e.vid = vid; e.status = st; e.err = err; e.wx = wx; e.wy = wy; e.wz = wz;
    e.miss = miss; e.sym = sym; e.eok = eok; e.td = td; e.lat = lat; e.start_cyc = 0;
    e.seal = seal_on ? {8{32'hD16E_0000 | 32'(vid)}} : '0;
    return e;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; lat_we = 1'b0; lat_addr = '0;
    lat_x = '0; lat_y = '0; lat_z = '0; vector_id = '0; epsilon = '0;
    bus_if.plugin_valid = '0;
    bus_if.seal_digest  = '0;
    for (int i = 0; i < 4; i++) begin
      bus_if.plugin_warp_x[i*16 +: 16] = 16'(i + 1);
      bus_if.plugin_warp_y[i*16 +: 16] = 16'(2 * (i + 1));
      bus_if.plugin_warp_z[i*16 +: 16] = 16'hFFFF;
      bus_if.plugin_error[i*32 +: 32]  = 32'd1;
    end
    repeat (3) @(negedge clk);
    chk("reset state", 256'(state), 256'(0));
    chk("reset plugin_ready", 256'(bus_if.plugin_ready), 256'(0));
    chk("reset seal_req", 256'(bus_if.seal_req), 256'(0));
    chk("reset seal_msg", 256'(bus_if.seal_msg), 256'(0));
    chk("reset status/done", 256'({status, done}), 256'(0));
    rst_n = 1'b1;
    load_lattice();

    run(mk(16'h0101, 2'd0, 32'd4, 16'd10, 16'd20, 16'hFFFC, 4'b0000, 1, 1, 1, 1, 16),
        32'd4, 4'hF, 1'b1, 0);
    run(mk(16'h0102, 2'd1, 32'd4, 16'd10, 16'd20, 16'hFFFC, 4'b0000, 1, 0, 0, 1, 16),
        32'd3, 4'hF, 1'b1, 0);
    run(mk(16'h0103, 2'd1, 32'd3, 16'd7, 16'd14, 16'hFFFD, 4'b0100, 1, 1, 0, 1, 79),
        32'd4, 4'b1011, 1'b1, 0);
    run(mk(16'h0104, 2'd2, 32'd4, 16'd10, 16'd20, 16'hFFFC, 4'b0000, 1, 1, 1, 0, 270),
        32'd4, 4'hF, 1'b0, 0);
    run(mk(16'h0105, 2'd3, 32'd4, 16'd10, 16'd20, 16'hFFFC, 4'b0000, 1, 1, 0, 0, 9),
        32'd4, 4'hF, 1'b1, 8);

    // Break mirror symmetry at point 3, then restore it.
    @(negedge clk);
    lat_we = 1'b1; lat_addr = 4'd3; lat_x = 16'h1234; lat_y = 16'd103; lat_z = -16'd3;
    @(negedge clk);
    lat_we = 1'b0;
    run(mk(16'h0106, 2'd1, 32'd4, 16'd10, 16'd20, 16'hFFFC, 4'b0000, 0, 1, 0, 1, 16),
        32'd4, 4'hF, 1'b1, 0);
    @(negedge clk);
    lat_we = 1'b1; lat_x = 16'd9;
    @(negedge clk);
    lat_we = 1'b0;

    bus_if.plugin_error = {32'd0, 32'd0, 32'h20, 32'hFFFF_FFF0};
`ifdef ISO16_SAT_ACCUM_EN
    run(mk(16'h0107, 2'd1, 32'hFFFF_FFFF, 16'd10, 16'd20, 16'hFFFC, 4'b0000, 1, 0, 0, 1, 16),
        32'd4, 4'hF, 1'b1, 0);
`else
    run(mk(16'h0107, 2'd1, 32'h10, 16'd10, 16'd20, 16'hFFFC, 4'b0000, 1, 0, 0, 1, 16),
        32'd4, 4'hF, 1'b1, 0);
`endif

    // Reset in the middle of COLLECT clears the run state.
    @(negedge clk);
    bus_if.plugin_valid = 4'hF; start = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("midrun reset state", 256'(state), 256'(0));
    chk("midrun reset error_sum", 256'(error_sum), 256'(0));
    chk("midrun reset warp_x", 256'(warp_sum_x), 256'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("scoreboard drained", 256'(exp_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
